// File: rtl/onehot_pulse_decoder.sv
// Binary index to one-hot strobe held for HOLD cycles, with done pulse.
// Optional one-entry skid buffer enabled by defining ONEHOT_DEC_SKID_EN.
module onehot_pulse_decoder #(
    parameter int W    = 2,
    parameter int HOLD = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2**W-1:0]  out_onehot,
    output logic             out_valid,
    output logic             done
);
    localparam int N  = 2**W;
    localparam int CW = $clog2(HOLD+1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD-1);

    if (HOLD < 1) begin : g_hold_chk
        $error("onehot_pulse_decoder: HOLD must be 1 or more");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          r_state, w_state_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [N-1:0]    r_oh, w_oh_n;
    logic            r_val, w_val_n;
    logic            r_done, w_done_n;
    logic            w_xfer;

`ifdef ONEHOT_DEC_SKID_EN
    logic [W-1:0]    r_pend_code, w_pend_code_n;
    logic            r_pend_full, w_pend_full_n;
`endif

    always_comb begin
        unique case (r_state)
            IDLE:    in_ready = 1'b1;
`ifdef ONEHOT_DEC_SKID_EN
            ACTIVE:  in_ready = !r_pend_full;
`else
            ACTIVE:  in_ready = 1'b0;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    assign w_xfer = in_valid & in_ready;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_oh_n    = r_oh;
        w_val_n   = r_val;
        w_done_n  = 1'b0;
`ifdef ONEHOT_DEC_SKID_EN
        w_pend_code_n = r_pend_code;
        w_pend_full_n = r_pend_full;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_oh_n    = N'(1) << in_code;
                    w_val_n   = 1'b1;
                    w_cnt_n   = CNT_LOAD;
                    w_state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - 1'b1;
`ifdef ONEHOT_DEC_SKID_EN
                    if (w_xfer) begin
                        w_pend_code_n = in_code;
                        w_pend_full_n = 1'b1;
                    end
`endif
                end else begin
                    w_done_n = 1'b1;
`ifdef ONEHOT_DEC_SKID_EN
                    // Back-to-back reload keeps out_valid high with no gap.
                    if (r_pend_full) begin
                        w_oh_n        = N'(1) << r_pend_code;
                        w_cnt_n       = CNT_LOAD;
                        w_pend_full_n = 1'b0;
                    end else if (w_xfer) begin
                        w_oh_n  = N'(1) << in_code;
                        w_cnt_n = CNT_LOAD;
                    end else begin
                        w_oh_n    = '0;
                        w_val_n   = 1'b0;
                        w_state_n = IDLE;
                    end
`else
                    w_oh_n    = '0;
                    w_val_n   = 1'b0;
                    w_state_n = IDLE;
`endif
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
                w_oh_n    = '0;
                w_val_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_oh    <= '0;
            r_val   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_oh    <= w_oh_n;
            r_val   <= w_val_n;
            r_done  <= w_done_n;
        end
    end

`ifdef ONEHOT_DEC_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_code <= '0;
            r_pend_full <= 1'b0;
        end else begin
            r_pend_code <= w_pend_code_n;
            r_pend_full <= w_pend_full_n;
        end
    end
`endif

    assign out_onehot = r_oh;
    assign out_valid  = r_val;
    assign done       = r_done;

endmodule
